// File: rtl/hazard_control_unit_pkg.sv
// Shared CPU definitions: sequencer state encoding, counter width and the
// opcode constants the control unit and hazard sequencer agree on.
package cpu_defs;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MULDIV     = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } hcu_state_e;

  // Opcode field [15:12] values shared with the control unit.
  localparam logic [3:0] OPC_LOAD   = 4'h4;
  localparam logic [3:0] OPC_MULDIV = 4'h6;
  localparam logic [3:0] OPC_BRANCH = 4'hc;
  localparam logic [3:0] OPC_JUMP   = 4'hd;
  localparam logic [3:0] OPC_HALT   = 4'hf;

  // Counter preload for a wait of `cycles`, less the cycles already spent
  // before the counter starts counting.
  function automatic logic [CNT_W-1:0] cnt_preload(input int cycles, input int spent);
    return CNT_W'(cycles - spent);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard information from ID/EX into the sequencer and the PC / buffer
// control pins back out to the pipeline.
interface hazard_control_unit_if;
  logic [3:0] id_op1;
  logic [3:0] id_op2;
  logic       id_uses_op1;
  logic       id_uses_op2;
  logic       id_halt;
  logic       ex_mem_read;
  logic [3:0] ex_write_reg;
  logic       ex_muldiv;
  logic       ex_branch_taken;
  logic       if_pc_stop;
  logic       if_pc_mux;
  logic       if_id_buffer_hold;
  logic       if_id_buffer_flush;
  logic       id_ex_buffer_hold;
  logic       id_ex_buffer_flush;
  logic       ex_mem_buffer_flush;
  logic       halted;

  // Pipeline side: supplies hazard info, receives controls.
  modport master (
    output id_op1, id_op2, id_uses_op1, id_uses_op2, id_halt,
           ex_mem_read, ex_write_reg, ex_muldiv, ex_branch_taken,
    input  if_pc_stop, if_pc_mux, if_id_buffer_hold, if_id_buffer_flush,
           id_ex_buffer_hold, id_ex_buffer_flush, ex_mem_buffer_flush, halted
  );

  // Sequencer side.
  modport slave (
    input  id_op1, id_op2, id_uses_op1, id_uses_op2, id_halt,
           ex_mem_read, ex_write_reg, ex_muldiv, ex_branch_taken,
    output if_pc_stop, if_pc_mux, if_id_buffer_hold, if_id_buffer_flush,
           id_ex_buffer_hold, id_ex_buffer_flush, ex_mem_buffer_flush, halted
  );
endinterface

// File: rtl/hazard_control_unit_load_use_detect.sv
// Load-use compare: a load in EX whose destination matches any register the
// ID instruction actually reads. R0 is compared like any other register.
module load_use_detect
  import cpu_defs::*;
(
  input  logic [3:0] id_op1,
  input  logic [3:0] id_op2,
  input  logic       id_uses_op1,
  input  logic       id_uses_op2,
  input  logic       ex_mem_read,
  input  logic [3:0] ex_write_reg,
  output logic       load_use
);

  logic [1:0][3:0] src;
  logic [1:0]      src_used;
  logic [1:0]      src_match;

  assign src      = {id_op2, id_op1};
  assign src_used = {id_uses_op2, id_uses_op1};

  // One comparator per ID source port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_match[gi] = src_used[gi] && (src[gi] == ex_write_reg);
  end

  assign load_use = ex_mem_read && (|src_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: PC stop/select and IF/ID, ID/EX, EX/MEM buffer controls
// for branches, load-use interlocks, multi-cycle muldiv and halt drain.
module hazard_control_unit
  import cpu_defs::*;
#(
  parameter int MULDIV_CYCLES = 4,  // 2..15
  parameter int DRAIN_CYCLES  = 3
) (
  input logic                  clock,
  input logic                  reset,
  hazard_control_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MULDIV_LOAD = cnt_preload(MULDIV_CYCLES, 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = cnt_preload(DRAIN_CYCLES, 1);

  hcu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_use;

  load_use_detect u_load_use_detect (
    .id_op1       (bus.id_op1),
    .id_op2       (bus.id_op2),
    .id_uses_op1  (bus.id_uses_op1),
    .id_uses_op2  (bus.id_uses_op2),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_write_reg (bus.ex_write_reg),
    .load_use     (load_use)
  );

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and control outputs; everything is forced low while reset is held.
  always_comb begin
    state_next              = state_reg;
    cnt_next                = cnt_reg;
    bus.if_pc_stop          = 1'b0;
    bus.if_pc_mux           = 1'b0;
    bus.if_id_buffer_hold   = 1'b0;
    bus.if_id_buffer_flush  = 1'b0;
    bus.id_ex_buffer_hold   = 1'b0;
    bus.id_ex_buffer_flush  = 1'b0;
    bus.ex_mem_buffer_flush = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (bus.ex_branch_taken) begin
            // ID holds a wrong-path instruction, so its hazards are moot.
            bus.if_pc_mux          = 1'b1;
            bus.if_id_buffer_flush = 1'b1;
            bus.id_ex_buffer_flush = 1'b1;
          end else if (bus.ex_muldiv) begin
            bus.if_pc_stop          = 1'b1;
            bus.if_id_buffer_hold   = 1'b1;
            bus.id_ex_buffer_hold   = 1'b1;
            bus.ex_mem_buffer_flush = 1'b1;
            state_next              = MULDIV;
            cnt_next                = MULDIV_LOAD;
          end else if (load_use) begin
            bus.if_pc_stop         = 1'b1;
            bus.if_id_buffer_hold  = 1'b1;
            bus.id_ex_buffer_flush = 1'b1;
          end else if (bus.id_halt) begin
            bus.if_pc_stop         = 1'b1;
            bus.if_id_buffer_flush = 1'b1;
            state_next             = HALT_DRAIN;
            cnt_next               = DRAIN_LOAD;
          end
        end
        MULDIV: begin
          // Final occupancy cycle: result latches into EX/MEM, stall released.
          if (cnt_reg == '0) begin
            state_next = RUN;
          end else begin
            bus.if_pc_stop          = 1'b1;
            bus.if_id_buffer_hold   = 1'b1;
            bus.id_ex_buffer_hold   = 1'b1;
            bus.ex_mem_buffer_flush = 1'b1;
            cnt_next                = cnt_reg - 4'd1;
          end
        end
        HALT_DRAIN: begin
          bus.if_pc_stop         = 1'b1;
          bus.if_id_buffer_flush = 1'b1;
          bus.id_ex_buffer_flush = 1'b1;
          if (cnt_reg == '0) state_next = HALTED;
          else               cnt_next   = cnt_reg - 4'd1;
        end
        HALTED: begin
          bus.if_pc_stop         = 1'b1;
          bus.if_id_buffer_flush = 1'b1;
          bus.id_ex_buffer_flush = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // halted comes straight from the state register.
  assign bus.halted = (state_reg == HALTED);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus a
// randomized run against a cycle-count based reference model.
module tb_hazard_control_unit;

  localparam int MULDIV_CYCLES = 4;
  localparam int DRAIN_CYCLES  = 3;

  // Output vector bit map: {stop, mux, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_flush, halted}
  localparam logic [7:0] O_STOP        = 8'h80;
  localparam logic [7:0] O_MUX         = 8'h40;
  localparam logic [7:0] O_IFID_HOLD   = 8'h20;
  localparam logic [7:0] O_IFID_FLUSH  = 8'h10;
  localparam logic [7:0] O_IDEX_HOLD   = 8'h08;
  localparam logic [7:0] O_IDEX_FLUSH  = 8'h04;
  localparam logic [7:0] O_EXMEM_FLUSH = 8'h02;
  localparam logic [7:0] O_HALTED      = 8'h01;

  localparam logic [7:0] E_BRANCH = O_MUX | O_IFID_FLUSH | O_IDEX_FLUSH;
  localparam logic [7:0] E_MULDIV = O_STOP | O_IFID_HOLD | O_IDEX_HOLD | O_EXMEM_FLUSH;
  localparam logic [7:0] E_LDUSE  = O_STOP | O_IFID_HOLD | O_IDEX_FLUSH;
  localparam logic [7:0] E_HALTIN = O_STOP | O_IFID_FLUSH;
  localparam logic [7:0] E_DRAIN  = O_STOP | O_IFID_FLUSH | O_IDEX_FLUSH;
  localparam logic [7:0] E_HALTED = E_DRAIN | O_HALTED;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hazard_control_unit_if bus_if ();

  hazard_control_unit #(
    .MULDIV_CYCLES (MULDIV_CYCLES),
    .DRAIN_CYCLES  (DRAIN_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [7:0] got;
  assign got = {bus_if.if_pc_stop, bus_if.if_pc_mux, bus_if.if_id_buffer_hold,
                bus_if.if_id_buffer_flush, bus_if.id_ex_buffer_hold,
                bus_if.id_ex_buffer_flush, bus_if.ex_mem_buffer_flush, bus_if.halted};

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: remaining occupancy / drain cycles and a halted flag.
  int m_md_left    = 0;
  int m_drain_left = 0;
  bit m_halted     = 1'b0;

  function automatic bit ref_load_use();
    return bus_if.ex_mem_read &&
           ((bus_if.id_uses_op1 && (bus_if.id_op1 == bus_if.ex_write_reg)) ||
            (bus_if.id_uses_op2 && (bus_if.id_op2 == bus_if.ex_write_reg)));
  endfunction

  function automatic logic [7:0] model_out();
    if (reset)             return 8'h00;
    if (m_halted)          return E_HALTED;
    if (m_drain_left > 0)  return E_DRAIN;
    if (m_md_left > 1)     return E_MULDIV;
    if (m_md_left == 1)    return 8'h00;
    if (bus_if.ex_branch_taken) return E_BRANCH;
    if (bus_if.ex_muldiv)  return E_MULDIV;
    if (ref_load_use())    return E_LDUSE;
    if (bus_if.id_halt)    return E_HALTIN;
    return 8'h00;
  endfunction

  task automatic model_step();
    if (reset || m_halted) begin
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else if (m_md_left > 0) begin
      m_md_left--;
    end else if (bus_if.ex_branch_taken) begin
    end else if (bus_if.ex_muldiv) begin
      m_md_left = MULDIV_CYCLES - 1;
    end else if (ref_load_use()) begin
    end else if (bus_if.id_halt) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic model_clear();
    m_md_left    = 0;
    m_drain_left = 0;
    m_halted     = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] op1, input logic [3:0] op2, input logic u1,
                        input logic u2, input logic halt, input logic mr,
                        input logic [3:0] wr, input logic md, input logic br);
    bus_if.id_op1          = op1;
    bus_if.id_op2          = op2;
    bus_if.id_uses_op1     = u1;
    bus_if.id_uses_op2     = u2;
    bus_if.id_halt         = halt;
    bus_if.ex_mem_read     = mr;
    bus_if.ex_write_reg    = wr;
    bus_if.ex_muldiv       = md;
    bus_if.ex_branch_taken = br;
  endtask

  task automatic clear_in();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Advance one clock: model follows the edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    set_in(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
    #2;
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_hold: got %b required %b", got, 8'h00);
    end
    @(negedge clock);
    reset = 1'b0;
    clear_in();
    model_clear();
    #1;
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_release: got %b required %b", got, 8'h00);
    end
    tick();
    @(negedge clock);
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b required %b", got, 8'h00);
    end
    tick();
  endtask

  task automatic test_load_use();
    // {op1, op2, u1, u2, wr, expected}
    logic [3:0] t_op1 [4] = '{4'd3, 4'd5, 4'd3, 4'd7};
    logic [3:0] t_op2 [4] = '{4'd1, 4'd0, 4'd2, 4'd2};
    logic       t_u1  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       t_u2  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] t_wr  [4] = '{4'd3, 4'd0, 4'd3, 4'd3};
    logic [7:0] t_exp [4] = '{E_LDUSE, E_LDUSE, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      set_in(t_op1[i], t_op2[i], t_u1[i], t_u2[i], 1'b0, 1'b1, t_wr[i], 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if (got !== t_exp[i]) begin
        tests_failed++;
        $display("FAIL load_use_%0d: got %b required %b", i, got, t_exp[i]);
      end
      tick();
      clear_in();
      @(negedge clock);
      tests_run++;
      if (got !== 8'h00) begin
        tests_failed++;
        $display("FAIL load_use_after_%0d: got %b required %b", i, got, 8'h00);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    int stalls = 0;
    logic [7:0] exp;
    set_in(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    for (int c = 0; c < MULDIV_CYCLES; c++) begin
      exp = (c < MULDIV_CYCLES - 1) ? E_MULDIV : 8'h00;
      @(negedge clock);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL muldiv_cycle_%0d: got %b required %b", c, got, exp);
      end
      if (got[7]) stalls++;
      tick();
      // Branch and halt during occupancy must be ignored.
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    end
    tests_run++;
    if (stalls != MULDIV_CYCLES - 1) begin
      tests_failed++;
      $display("FAIL muldiv_stall_count: got %0d required %0d", stalls, MULDIV_CYCLES - 1);
    end
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clock);
    tests_run++;
    if (got !== E_BRANCH) begin
      tests_failed++;
      $display("FAIL muldiv_back_in_run: got %b required %b", got, E_BRANCH);
    end
    tick();
    clear_in();
  endtask

  task automatic test_branch_priority();
    // Branch together with a load-use match.
    set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    @(negedge clock);
    tests_run++;
    if (got !== E_BRANCH) begin
      tests_failed++;
      $display("FAIL branch_vs_load: got %b required %b", got, E_BRANCH);
    end
    tick();
    // Branch together with halt: halt dropped, no drain afterwards.
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clock);
    tests_run++;
    if (got !== E_BRANCH) begin
      tests_failed++;
      $display("FAIL branch_vs_halt: got %b required %b", got, E_BRANCH);
    end
    tick();
    clear_in();
    @(negedge clock);
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL branch_vs_halt_after: got %b required %b", got, 8'h00);
    end
    tick();
  endtask

  task automatic test_halt_drain();
    logic [7:0] exp;
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (got !== E_HALTIN) begin
      tests_failed++;
      $display("FAIL halt_accept: got %b required %b", got, E_HALTIN);
    end
    tick();
    for (int k = 1; k <= DRAIN_CYCLES + 4; k++) begin
      set_in(4'($urandom_range(0, 3)), 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 3)),
             1'b0, 1'($urandom_range(0, 1)));
      exp = (k <= DRAIN_CYCLES) ? E_DRAIN : E_HALTED;
      @(negedge clock);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL halt_drain_%0d: got %b required %b", k, got, exp);
      end
      tick();
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL halt_reset: got %b required %b", got, 8'h00);
    end
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_in();
  endtask

  task automatic test_reset_mid_muldiv();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clock);
    tests_run++;
    if (got !== E_MULDIV) begin
      tests_failed++;
      $display("FAIL rst_md_first: got %b required %b", got, E_MULDIV);
    end
    tick();
    clear_in();
    @(negedge clock);
    tests_run++;
    if (got !== E_MULDIV) begin
      tests_failed++;
      $display("FAIL rst_md_second: got %b required %b", got, E_MULDIV);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_md_immediate: got %b required %b", got, 8'h00);
    end
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_md_fetch: got %b required %b", got, 8'h00);
    end
    tick();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clock);
    tests_run++;
    if (got !== E_BRANCH) begin
      tests_failed++;
      $display("FAIL rst_md_run: got %b required %b", got, E_BRANCH);
    end
    tick();
    clear_in();
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    logic [7:0] exp;
    logic mr;
    for (int n = 0; n < 600; n++) begin
      if ((halted_cycles > 4) || ($urandom_range(0, 59) == 0)) begin
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests_run++;
        if (got !== 8'h00) begin
          tests_failed++;
          $display("FAIL random_reset_%0d: got %b required %b", n, got, 8'h00);
        end
        model_clear();
        halted_cycles = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
      end else begin
        mr = ($urandom_range(0, 2) == 0);
        set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), mr,
               4'($urandom_range(0, 3)), (!mr) && ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 5) == 0));
        @(negedge clock);
        exp = model_out();
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL random_%0d: got %b required %b", n, got, exp);
        end
        tick();
        if (m_halted) halted_cycles++;
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch_priority();
    test_halt_drain();
    test_reset_mid_muldiv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion required completion");
    $fatal(1, "timeout");
  end

endmodule
